uart_apb_ctrl: RTL and testbench
================================

Name: uart_apb_ctrl

Overview:
APB master that initialises the myuart register block and then services it autonomously. Its TX byte FIFO removes the one-THR-write-per-TXEMPTY limitation for the requester. It also drains RHR into a valid/ready RX stream and handles SR clear writes. It sits between an on-chip byte producer/consumer and the myuart APB slave port, on the pclk domain.

Parameters:
TX_FIFO_DEPTH, 4, TX byte FIFO entries; power of two, minimum 2.
POLL_INTERVAL, 64, idle cycles between unsolicited SR polls; range 1..65535.
BRGR_INIT, 32'h00103E01, value written to BRGR at start-up.
CR_INIT, 32'h00000272, value written to CR at start-up.
IMR_INIT, 32'h00000005, value written to IMR at start-up.

Ports:
pclk_i  in  1  APB clock, sole clock
preset_n_i  in  1  asynchronous active-low reset
psel_o  out  1  APB select
penable_o  out  1  APB enable
pwrite_o  out  1  APB write (1) / read (0)
paddr_o  out  6  APB address
pwdata_o  out  32  APB write data
prdata_i  in  32  APB read data
interrupt_i  in  1  myuart interrupt_o
tx_valid_i  in  1  TX byte offered
tx_data_i  in  8  TX byte
tx_ready_o  out  1  TX FIFO not full
rx_valid_o  out  1  RX byte held
rx_data_o  out  8  RX byte
rx_ready_i  in  1  consumer accepts RX byte
cfg_done_o  out  1  start-up configuration complete
pare_err_o  out  1  sticky parity-error flag

Behaviour:
- Reset: preset_n_i is asynchronous and active-low. While it is low, all outputs are 0, the FIFO is empty, the poll counter is 0 and the FSM is in CFG_BRGR. Exception: tx_ready_o is also 0 during reset and goes to 1 on the first edge after release.
- Register map:
  - CR 0x04
  - THR/RHR 0x08
  - SR 0x0C
  - BRGR 0x10
  - IMR 0x14
  - SR bits: RXRDY 0, TXRDY 1, TXEMPTY 2, PARE 5.
- APB timing: there is no pready, so every transfer takes exactly 2 cycles.
  - SETUP: psel=1, penable=0.
  - ACCESS: psel=1, penable=1.
  - paddr, pwrite and pwdata are stable across both cycles.
  - prdata_i is sampled on the clock edge that ends ACCESS.
  - Back-to-back transfers are allowed; no idle cycle is required between them.
  - Between transfers, psel=0, penable=0, and paddr/pwdata hold their last value.
- Start-up sequence: CFG_BRGR, then CFG_CR, then CFG_IMR, each a write of its *_INIT value.
  - The first SETUP cycle is the first cycle after reset release.
  - cfg_done_o rises in cycle 7 and stays high until reset.
  - No TX or RX service happens before cfg_done_o is high.
- IDLE: the poll counter increments each idle cycle. RD_SR is entered when any of these is true:
  - interrupt_i=1,
  - TX FIFO non-empty,
  - poll counter == POLL_INTERVAL-1.
  The counter clears when RD_SR is entered.
- After RD_SR, the sampled SR value selects the next action (in priority order):
  1. RXRDY=1 and rx_valid_o=0: go to RD_RHR, load rx_data_o from prdata[7:0] and set rx_valid_o. Then go to WR_SRCLR with pwdata = {26'b0, PARE_sampled, 4'b0, 1'b1}.
  2. PARE=1 without RX service: go to WR_SRCLR with pwdata = 32'h20.
  3. TXRDY=1 and FIFO non-empty: go to WR_THR with pwdata = {24'b0, fifo_head}. The FIFO pops on the ACCESS edge.
  4. Otherwise: return to IDLE.
- After WR_SRCLR, return to IDLE; a fresh SR read governs TX.
- RX priority and backpressure:
  - RX is served before TX when both are ready.
  - If RXRDY=1 but rx_valid_o=1, RHR is not read and the SR clear is not written. Overrun handling is left to the UART.
- RX stream: rx_valid_o clears on the rx_valid_o & rx_ready_i edge. rx_data_o is stable while valid.
- pare_err_o: set whenever a sampled SR has PARE=1; cleared only by reset.
- TX FIFO:
  - push = tx_valid_i & tx_ready_o.
  - A simultaneous push and pop is allowed when full; the count is unchanged.
  - Pointers wrap modulo TX_FIFO_DEPTH. The count is clog2(TX_FIFO_DEPTH)+1 bits wide.
  - tx_ready_o = ~full.
- Reset mid-transfer: psel/penable drop immediately (asynchronously), buffered bytes are discarded and the full start-up sequence reruns.

Decomposition:
- Package uart_apb_pkg holds:
  - the register offsets (CR/THR/RHR/SR/BRGR/IMR),
  - the SR bit positions,
  - the FSM state enum: CFG_BRGR, CFG_CR, CFG_IMR, IDLE, RD_SR, RD_RHR, WR_SRCLR, WR_THR, each with a phase bit for SETUP/ACCESS.
- One sub-module: sync_fifo (parameterised width/depth, push/pop/full/empty/count), instanced for the TX path.

Test Plan:
- Config: release reset → writes 0x10=0x00103E01, 0x04=0x00000272, 0x14=0x00000005 in cycles 1-6, with no idle gap; cfg_done_o=1 at cycle 7.
- TX burst: push 0x93, 0x5A, 0xC3 back-to-back while the slave model returns SR=0x06 → three THR writes (0x08) with pwdata 0x93, 0x5A, 0xC3 in order; each is preceded by an SR read; tx_ready_o stays 1.
- RX: slave model asserts interrupt_i and returns SR=0x01, then RHR=0xAA → RHR read, then SR write 0x01; rx_valid_o=1 with rx_data_o=0xAA until rx_ready_i.
- Simultaneous: FIFO holds 0x11 and SR=0x03 → RHR read and SR clear occur before the THR write of 0x11.
- Backpressure and parity:
  - TX: with TXRDY=0, push 5 bytes at depth 4 → tx_ready_o=0 after 4; a 5th push is ignored until a pop.
  - RX: rx_valid_o=1, rx_ready_i=0 and SR=0x01 → no RHR read.
  - Parity: SR=0x21 → pare_err_o=1 and SR clear 0x21 is written.
- Reset mid-transfer: assert preset_n_i during WR_THR ACCESS → psel_o=0 at once; after release the config sequence repeats and the FIFO is empty.

Source files
------------

// File: rtl/uart_apb_pkg.sv
// Shared definitions for the myuart APB controller: register map, SR bits, FSM encoding.
package uart_apb_pkg;

    localparam logic [5:0] ADDR_CR   = 6'h04;
    localparam logic [5:0] ADDR_THR  = 6'h08;
    localparam logic [5:0] ADDR_RHR  = 6'h08;
    localparam logic [5:0] ADDR_SR   = 6'h0C;
    localparam logic [5:0] ADDR_BRGR = 6'h10;
    localparam logic [5:0] ADDR_IMR  = 6'h14;

    localparam int SR_RXRDY   = 0;
    localparam int SR_TXRDY   = 1;
    localparam int SR_TXEMPTY = 2;
    localparam int SR_PARE    = 5;

    // SR clear word used when only the parity flag needs acknowledging
    localparam logic [31:0] SR_CLR_PARE = 32'h0000_0020;

    typedef enum logic [2:0] {
        CFG_BRGR,
        CFG_CR,
        CFG_IMR,
        IDLE,
        RD_SR,
        RD_RHR,
        WR_SRCLR,
        WR_THR
    } state_e;

    typedef enum logic {
        PH_SETUP  = 1'b0,
        PH_ACCESS = 1'b1
    } phase_e;

    typedef struct packed {
        state_e state;
        phase_e phase;
    } fsm_t;

    function automatic logic [5:0] state_addr(input state_e s);
        case (s)
            CFG_BRGR: return ADDR_BRGR;
            CFG_CR:   return ADDR_CR;
            CFG_IMR:  return ADDR_IMR;
            RD_RHR:   return ADDR_RHR;
            WR_THR:   return ADDR_THR;
            default:  return ADDR_SR;
        endcase
    endfunction

    function automatic logic state_is_write(input state_e s);
        return !((s == RD_SR) || (s == RD_RHR));
    endfunction

endpackage

// File: rtl/uart_apb_ctrl_sync_fifo.sv
// Small synchronous FIFO with combinational head read-out.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == FULL_COUNT);
    assign empty   = (count == '0);
    // a pop in the same cycle frees the slot, so push is still taken when full
    assign do_push = push && (!full || pop);
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    // storage array, contents are don't-care until written
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (PTR_W+1)'(1);
                2'b01:   count <= count - (PTR_W+1)'(1);
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/uart_apb_ctrl.sv
// APB master that configures myuart at start-up, then services TX/RX and SR clears.
//
// state    | meaning
// CFG_BRGR | write BRGR_INIT to BRGR
// CFG_CR   | write CR_INIT to CR
// CFG_IMR  | write IMR_INIT to IMR, cfg_done_o set when it completes
// IDLE     | no transfer, poll counter runs
// RD_SR    | read SR, result picks the next action
// RD_RHR   | read RHR into the RX holding register
// WR_SRCLR | write SR to clear RXRDY and/or PARE
// WR_THR   | write FIFO head to THR, FIFO pops at the end of ACCESS
// Every non-IDLE state spends one SETUP and one ACCESS cycle.
module uart_apb_ctrl
    import uart_apb_pkg::*;
#(
    parameter int          TX_FIFO_DEPTH = 4,
    parameter int          POLL_INTERVAL = 64,
    parameter logic [31:0] BRGR_INIT     = 32'h0010_3E01,
    parameter logic [31:0] CR_INIT       = 32'h0000_0272,
    parameter logic [31:0] IMR_INIT      = 32'h0000_0005
) (
    input  logic        pclk_i,
    input  logic        preset_n_i,
    output logic        psel_o,
    output logic        penable_o,
    output logic        pwrite_o,
    output logic [5:0]  paddr_o,
    output logic [31:0] pwdata_o,
    input  logic [31:0] prdata_i,
    input  logic        interrupt_i,
    input  logic        tx_valid_i,
    input  logic [7:0]  tx_data_i,
    output logic        tx_ready_o,
    output logic        rx_valid_o,
    output logic [7:0]  rx_data_o,
    input  logic        rx_ready_i,
    output logic        cfg_done_o,
    output logic        pare_err_o
);

    localparam int          CNT_W     = $clog2(TX_FIFO_DEPTH) + 1;
    localparam logic [15:0] POLL_LAST = 16'(POLL_INTERVAL - 1);

    fsm_t        cur;
    fsm_t        nxt;
    logic        armed;
    logic [15:0] poll_cnt;
    logic        idle_go;
    logic        sr_pare;
    logic [31:0] nxt_wdata;
    logic        start_xfer;

    logic [7:0]       fifo_head;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CNT_W-1:0] fifo_count;
    logic             push;
    logic             pop;
    logic             unused_bits;

    assign unused_bits = ^{prdata_i[31:8], prdata_i[SR_TXEMPTY], fifo_count};

    // armed stays low for the cycle in which reset releases, which keeps every
    // output at zero until the first clock edge and makes that edge start BRGR
    assign idle_go    = interrupt_i || !fifo_empty || (poll_cnt == POLL_LAST);
    assign tx_ready_o = armed && !fifo_full;
    assign push       = tx_valid_i && tx_ready_o;
    assign start_xfer = (nxt.state != IDLE) && (nxt.phase == PH_SETUP) && (nxt != cur);

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (TX_FIFO_DEPTH)
    ) u_tx_fifo (
        .clk   (pclk_i),
        .rst_n (preset_n_i),
        .push  (push),
        .pop   (pop),
        .wdata (tx_data_i),
        .rdata (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // state register, held until the controller is armed
    always_ff @(posedge pclk_i or negedge preset_n_i) begin
        if (!preset_n_i) begin
            armed <= 1'b0;
            cur   <= '{state: CFG_BRGR, phase: PH_SETUP};
        end else begin
            armed <= 1'b1;
            if (armed) cur <= nxt;
        end
    end

    // next state and the write data for the transfer being entered
    always_comb begin
        nxt       = cur;
        nxt_wdata = 32'h0;
        if (cur.state == IDLE) begin
            if (idle_go) nxt = '{state: RD_SR, phase: PH_SETUP};
        end else if (cur.phase == PH_SETUP) begin
            nxt.phase = PH_ACCESS;
        end else begin
            nxt = '{state: IDLE, phase: PH_SETUP};
            case (cur.state)
                CFG_BRGR: begin
                    nxt.state = CFG_CR;
                    nxt_wdata = CR_INIT;
                end
                CFG_CR: begin
                    nxt.state = CFG_IMR;
                    nxt_wdata = IMR_INIT;
                end
                RD_SR: begin
                    if (prdata_i[SR_RXRDY] && !rx_valid_o) begin
                        nxt.state = RD_RHR;
                    end else if (prdata_i[SR_PARE]) begin
                        nxt.state = WR_SRCLR;
                        nxt_wdata = SR_CLR_PARE;
                    end else if (prdata_i[SR_TXRDY] && !fifo_empty) begin
                        nxt.state = WR_THR;
                        nxt_wdata = {24'h0, fifo_head};
                    end
                end
                RD_RHR: begin
                    nxt.state = WR_SRCLR;
                    nxt_wdata = {26'h0, sr_pare, 4'h0, 1'b1};
                end
                default: ;
            endcase
        end
    end

    // APB strobes and FIFO pop decoded from the current state
    always_comb begin
        psel_o    = 1'b0;
        penable_o = 1'b0;
        pop       = 1'b0;
        if (armed && (cur.state != IDLE)) begin
            psel_o    = 1'b1;
            penable_o = (cur.phase == PH_ACCESS);
            pop       = (cur.phase == PH_ACCESS) && (cur.state == WR_THR);
        end
    end

    // address/direction/data latched at the start of each SETUP, held in between
    always_ff @(posedge pclk_i or negedge preset_n_i) begin
        if (!preset_n_i) begin
            paddr_o  <= 6'h0;
            pwrite_o <= 1'b0;
            pwdata_o <= 32'h0;
        end else if (!armed) begin
            paddr_o  <= ADDR_BRGR;
            pwrite_o <= 1'b1;
            pwdata_o <= BRGR_INIT;
        end else if (start_xfer) begin
            paddr_o  <= state_addr(nxt.state);
            pwrite_o <= state_is_write(nxt.state);
            if (state_is_write(nxt.state)) pwdata_o <= nxt_wdata;
        end
    end

    // poll counter only runs while idle and restarts whenever SR is read
    always_ff @(posedge pclk_i or negedge preset_n_i) begin
        if (!preset_n_i) begin
            poll_cnt <= 16'h0;
        end else if (armed && (cur.state == IDLE)) begin
            poll_cnt <= idle_go ? 16'h0 : poll_cnt + 16'h1;
        end
    end

    // status capture, RX holding register and sticky flags
    always_ff @(posedge pclk_i or negedge preset_n_i) begin
        if (!preset_n_i) begin
            cfg_done_o <= 1'b0;
            pare_err_o <= 1'b0;
            sr_pare    <= 1'b0;
            rx_valid_o <= 1'b0;
            rx_data_o  <= 8'h0;
        end else begin
            if (penable_o && (cur.state == CFG_IMR)) cfg_done_o <= 1'b1;
            if (penable_o && (cur.state == RD_SR)) begin
                sr_pare <= prdata_i[SR_PARE];
                if (prdata_i[SR_PARE]) pare_err_o <= 1'b1;
            end
            if (penable_o && (cur.state == RD_RHR)) begin
                rx_valid_o <= 1'b1;
                rx_data_o  <= prdata_i[7:0];
            end else if (rx_valid_o && rx_ready_i) begin
                rx_valid_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_apb_ctrl.sv
// Directed bench for uart_apb_ctrl with a behavioural myuart slave.
module tb_uart_apb_ctrl;

    logic        pclk = 1'b0;
    logic        preset_n = 1'b0;
    logic        psel, penable, pwrite;
    logic [5:0]  paddr;
    logic [31:0] pwdata, prdata;
    logic        interrupt = 1'b0;
    logic        tx_valid = 1'b0;
    logic [7:0]  tx_data = 8'h0;
    logic        tx_ready, rx_valid;
    logic [7:0]  rx_data;
    logic        rx_ready = 1'b0;
    logic        cfg_done, pare_err;

    logic [31:0] sr_val = 32'h0;
    logic [31:0] rhr_val = 32'h0;
    int          errors = 0;
    int          checks = 0;
    int          cyc;
    logic        prev_setup = 1'b0;
    logic [5:0]  prev_addr = 6'h0;

    typedef struct {
        logic        wr;
        logic [5:0]  addr;
        logic [31:0] data;
        int          cyc;
    } xfer_t;

    xfer_t log_q[$];

    always #5 pclk = ~pclk;

    assign prdata = (psel && !pwrite) ?
                    ((paddr == 6'h0C) ? sr_val : (paddr == 6'h08) ? rhr_val : 32'h0) : 32'h0;

    uart_apb_ctrl dut (
        .pclk_i      (pclk),
        .preset_n_i  (preset_n),
        .psel_o      (psel),
        .penable_o   (penable),
        .pwrite_o    (pwrite),
        .paddr_o     (paddr),
        .pwdata_o    (pwdata),
        .prdata_i    (prdata),
        .interrupt_i (interrupt),
        .tx_valid_i  (tx_valid),
        .tx_data_i   (tx_data),
        .tx_ready_o  (tx_ready),
        .rx_valid_o  (rx_valid),
        .rx_data_o   (rx_data),
        .rx_ready_i  (rx_ready),
        .cfg_done_o  (cfg_done),
        .pare_err_o  (pare_err)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(posedge pclk or negedge preset_n) begin
        if (!preset_n) cyc <= 0;
        else           cyc <= cyc + 1;
    end

    always @(negedge pclk) begin
        if (psel && penable) begin
            check("apb_setup", {57'h0, prev_setup, prev_addr}, {57'h0, 1'b1, paddr});
            log_q.push_back('{wr: pwrite, addr: paddr, data: (pwrite ? pwdata : prdata), cyc: cyc});
        end
        prev_setup <= psel && !penable;
        prev_addr  <= paddr;
    end

    task automatic next_xfer(input string tag, output xfer_t x);
        int n = 0;
        x = '{wr: 1'b0, addr: 6'h0, data: 32'h0, cyc: 0};
        while (log_q.size() == 0 && n < 300) begin
            @(negedge pclk);
            n++;
        end
        if (log_q.size() == 0) check({tag, "_timeout"}, 64'd0, 64'd1);
        else x = log_q.pop_front();
    endtask

    task automatic expect_xfer(input string tag, input logic wr, input logic [5:0] addr,
                               input logic [31:0] data);
        xfer_t x;
        next_xfer(tag, x);
        check(tag, {25'h0, x.wr, x.addr, x.data}, {25'h0, wr, addr, data});
    endtask

    task automatic next_write(input string tag, output xfer_t x);
        int   n = 0;
        logic found = 1'b0;
        x = '{wr: 1'b0, addr: 6'h0, data: 32'h0, cyc: 0};
        while (!found && n < 300) begin
            if (log_q.size() > 0) begin
                x = log_q.pop_front();
                found = x.wr;
            end else begin
                @(negedge pclk);
                n++;
            end
        end
        if (!found) check({tag, "_timeout"}, 64'd0, 64'd1);
    endtask

    // called at the negedge where reset was just released (cycle 0)
    task automatic run_config(input string tag);
        xfer_t       x;
        logic [5:0]  ca[3];
        logic [31:0] cd[3];
        ca = '{6'h10, 6'h04, 6'h14};
        cd = '{32'h0010_3E01, 32'h0000_0272, 32'h0000_0005};
        check({tag, "_c0"}, {62'h0, psel, tx_ready}, 64'h0);
        @(negedge pclk);
        check({tag, "_setup1"}, {22'h0, psel, penable, pwrite, paddr, pwdata, tx_ready},
              {22'h0, 1'b1, 1'b0, 1'b1, 6'h10, 32'h0010_3E01, 1'b1});
        repeat (5) @(negedge pclk);
        check({tag, "_done_c6"}, {63'h0, cfg_done}, 64'h0);
        @(negedge pclk);
        check({tag, "_done_c7"}, {63'h0, cfg_done}, 64'h1);
        for (int i = 0; i < 3; i++) begin
            next_xfer(tag, x);
            check({tag, "_wr"}, {25'h0, x.wr, x.addr, x.data}, {25'h0, 1'b1, ca[i], cd[i]});
            check({tag, "_cyc"}, 64'(x.cyc), 64'(2 * i + 2));
        end
        next_xfer(tag, x);
        check({tag, "_poll"}, {25'h0, x.wr, x.addr, x.data}, {25'h0, 1'b0, 6'h0C, 32'h0});
        check({tag, "_poll_cyc"}, 64'(x.cyc), 64'd72);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        xfer_t       x;
        int          n;
        int          nw;
        logic [7:0]  burst[3];
        logic [7:0]  bp[5];
        burst = '{8'h93, 8'h5A, 8'hC3};
        bp    = '{8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5};

        repeat (3) @(negedge pclk);
        check("rst_outputs",
              {11'h0, psel, penable, pwrite, tx_ready, rx_valid, cfg_done, pare_err, paddr, pwdata, rx_data},
              64'h0);
        preset_n = 1'b1;
        run_config("cfg");

        next_xfer("poll2", x);
        check("poll2", {25'h0, x.wr, x.addr, x.data}, {25'h0, 1'b0, 6'h0C, 32'h0});
        check("poll2_cyc", 64'(x.cyc), 64'd138);

        // TX burst with TXRDY|TXEMPTY
        sr_val = 32'h06;
        for (int i = 0; i < 3; i++) begin
            tx_data  = burst[i];
            tx_valid = 1'b1;
            check("tx_burst_ready", {63'h0, tx_ready}, 64'h1);
            @(negedge pclk);
        end
        tx_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            expect_xfer("tx_sr", 1'b0, 6'h0C, 32'h06);
            expect_xfer("tx_thr", 1'b1, 6'h08, {24'h0, burst[i]});
        end
        sr_val = 32'h0;
        repeat (5) @(negedge pclk);
        check("tx_quiet", 64'(log_q.size()), 64'd0);

        // RX byte via interrupt
        sr_val = 32'h01; rhr_val = 32'hAA; interrupt = 1'b1;
        expect_xfer("rx_sr", 1'b0, 6'h0C, 32'h01);
        interrupt = 1'b0;
        expect_xfer("rx_rhr", 1'b0, 6'h08, 32'hAA);
        expect_xfer("rx_clr", 1'b1, 6'h0C, 32'h01);
        sr_val = 32'h0;
        repeat (4) @(negedge pclk);
        check("rx_hold", {55'h0, rx_valid, rx_data}, {55'h0, 1'b1, 8'hAA});

        // RX backpressure: RXRDY while holding a byte must not read RHR
        sr_val = 32'h01; interrupt = 1'b1;
        expect_xfer("bp_sr1", 1'b0, 6'h0C, 32'h01);
        expect_xfer("bp_sr2", 1'b0, 6'h0C, 32'h01);
        interrupt = 1'b0; sr_val = 32'h0;
        repeat (6) @(negedge pclk);
        log_q.delete();
        check("rx_bp_hold", {55'h0, rx_valid, rx_data}, {55'h0, 1'b1, 8'hAA});
        rx_ready = 1'b1;
        @(negedge pclk);
        rx_ready = 1'b0;
        check("rx_accept", {63'h0, rx_valid}, 64'h0);

        // RX and TX ready together: RX is served first
        sr_val = 32'h03; rhr_val = 32'h5C;
        tx_data = 8'h11; tx_valid = 1'b1;
        @(negedge pclk);
        tx_valid = 1'b0;
        expect_xfer("sim_sr1", 1'b0, 6'h0C, 32'h03);
        expect_xfer("sim_rhr", 1'b0, 6'h08, 32'h5C);
        expect_xfer("sim_clr", 1'b1, 6'h0C, 32'h01);
        expect_xfer("sim_sr2", 1'b0, 6'h0C, 32'h03);
        expect_xfer("sim_thr", 1'b1, 6'h08, 32'h11);
        sr_val = 32'h0;
        check("sim_rx", {55'h0, rx_valid, rx_data}, {55'h0, 1'b1, 8'h5C});
        rx_ready = 1'b1;
        @(negedge pclk);
        rx_ready = 1'b0;

        // TX backpressure: TXRDY=0, fill the FIFO and offer a fifth byte
        sr_val = 32'h0;
        for (int i = 0; i < 4; i++) begin
            tx_data = bp[i]; tx_valid = 1'b1;
            @(negedge pclk);
        end
        check("bp_full", {63'h0, tx_ready}, 64'h0);
        tx_data = bp[4];
        repeat (5) @(negedge pclk);
        check("bp_hold", {63'h0, tx_ready}, 64'h0);
        log_q.delete();
        sr_val = 32'h02;
        n = 0;
        while (!tx_ready && n < 50) begin
            @(negedge pclk);
            n++;
        end
        check("bp_reopen", {63'h0, tx_ready}, 64'h1);
        @(negedge pclk);
        tx_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            next_write("bp_thr", x);
            check("bp_thr", {26'h0, x.addr, x.data}, {26'h0, 6'h08, 24'h0, bp[i]});
        end
        sr_val = 32'h0;
        repeat (10) @(negedge pclk);
        nw = 0;
        foreach (log_q[i]) if (log_q[i].wr) nw++;
        check("bp_no_extra", 64'(nw), 64'd0);
        log_q.delete();

        // parity together with an RX byte
        check("pare_clear", {63'h0, pare_err}, 64'h0);
        sr_val = 32'h21; rhr_val = 32'h3C; interrupt = 1'b1;
        expect_xfer("par_sr", 1'b0, 6'h0C, 32'h21);
        interrupt = 1'b0; sr_val = 32'h0;
        expect_xfer("par_rhr", 1'b0, 6'h08, 32'h3C);
        expect_xfer("par_clr", 1'b1, 6'h0C, 32'h21);
        check("par_flag", {55'h0, pare_err, rx_data}, {55'h0, 1'b1, 8'h3C});

        // parity alone while the RX byte is still held
        sr_val = 32'h20; interrupt = 1'b1;
        expect_xfer("paro_sr", 1'b0, 6'h0C, 32'h20);
        interrupt = 1'b0; sr_val = 32'h0;
        expect_xfer("paro_clr", 1'b1, 6'h0C, 32'h20);
        rx_ready = 1'b1;
        @(negedge pclk);
        rx_ready = 1'b0;
        check("paro_sticky", {62'h0, pare_err, rx_valid}, {62'h0, 1'b1, 1'b0});

        // reset during a THR write ACCESS
        sr_val = 32'h02; tx_data = 8'h77; tx_valid = 1'b1;
        @(negedge pclk);
        tx_valid = 1'b0;
        n = 0;
        while (!(psel && penable && pwrite && paddr == 6'h08) && n < 50) begin
            @(negedge pclk);
            n++;
        end
        check("rst_mid_found", {63'h0, psel && penable}, 64'h1);
        #2 preset_n = 1'b0;
        #1 check("rst_mid_async", {59'h0, psel, penable, tx_ready, cfg_done, pare_err}, 64'h0);
        sr_val = 32'h0;
        @(negedge pclk);
        @(negedge pclk);
        log_q.delete();
        preset_n = 1'b1;
        run_config("rst2");
        check("rst2_flags", {62'h0, tx_ready, pare_err}, {62'h0, 1'b1, 1'b0});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
